// File: rtl/rover_route_driver_pkg.sv
// rover_pkg: shared definitions for the land rover and its route driver.
//   - room_t and the R0..R7 room constants (also used by the rover FSM)
//   - succ(room, b): rover successor room for travel bit b
//   - DIST: 8x8 shortest-hop table [from][to], built once at elaboration
//   - nexthop(room, target): travel bit that moves one step along a
//     shortest path (ties resolve to 1, 0 when already at target)
package rover_pkg;

    typedef logic [2:0] room_t;
    typedef logic [3:0] dist_t;
    typedef logic [7:0][7:0][3:0] dist_tab_t;

    localparam int unsigned NROOMS = 8;

    localparam room_t R0 = 3'd0;
    localparam room_t R1 = 3'd1;
    localparam room_t R2 = 3'd2;
    localparam room_t R3 = 3'd3;
    localparam room_t R4 = 3'd4;
    localparam room_t R5 = 3'd5;
    localparam room_t R6 = 3'd6;
    localparam room_t R7 = 3'd7;

    function automatic room_t succ(input room_t room, input logic b);
        room_t r;
        case (room)
            R0:      r = b ? R1 : R0;
            R1:      r = b ? R2 : R0;
            R2:      r = b ? R3 : R2;
            R3:      r = b ? R4 : R2;
            R4:      r = b ? R6 : R4;
            R5:      r = b ? R7 : R6;
            R6:      r = b ? R4 : R5;
            default: r = b ? R0 : R7;
        endcase
        return r;
    endfunction

    // Level-by-level BFS from every source room; unreachable stays at 15.
    function automatic dist_tab_t build_dist();
        dist_tab_t  d;
        logic [7:0] seen;
        logic [7:0] frontier;
        logic [7:0] reach;
        d = '1;
        for (int unsigned a = 0; a < NROOMS; a++) begin
            seen = '0;
            seen[room_t'(a)] = 1'b1;
            frontier = seen;
            d[room_t'(a)][room_t'(a)] = '0;
            for (int unsigned lvl = 1; lvl < NROOMS; lvl++) begin
                reach = '0;
                for (int unsigned r = 0; r < NROOMS; r++) begin
                    if (frontier[room_t'(r)]) begin
                        reach[succ(room_t'(r), 1'b0)] = 1'b1;
                        reach[succ(room_t'(r), 1'b1)] = 1'b1;
                    end
                end
                reach &= ~seen;
                for (int unsigned r = 0; r < NROOMS; r++) begin
                    if (reach[room_t'(r)]) begin
                        d[room_t'(a)][room_t'(r)] = dist_t'(lvl);
                    end
                end
                seen |= reach;
                frontier = reach;
            end
        end
        return d;
    endfunction

    localparam dist_tab_t DIST = build_dist();

    function automatic logic nexthop(input room_t room, input room_t target);
        logic b;
        if (room == target) begin
            b = 1'b0;
        end else begin
            b = (DIST[succ(room, 1'b0)][target] < DIST[succ(room, 1'b1)][target]) ? 1'b0 : 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/rover_route_driver_if.sv
// Target-command handshake between the mission controller (master) and
// the route driver (slave).
//   cmd_valid : a target command is offered
//   cmd_room  : target room
//   cmd_ready : driver can take a command (idle)
interface rover_route_driver_if;
    import rover_pkg::*;

    logic  cmd_valid;
    room_t cmd_room;
    logic  cmd_ready;

    modport master (output cmd_valid, output cmd_room, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_room, output cmd_ready);
endinterface

// File: rtl/rover_nexthop.sv
// Combinational next-hop selector.
//   room_i      : rover current room
//   target_i    : destination room
//   bit_o       : travel bit along a shortest path (0 at target)
//   next_room_o : room the rover reaches after applying bit_o
module rover_nexthop
    import rover_pkg::*;
(
    input  room_t room_i,
    input  room_t target_i,
    output logic  bit_o,
    output room_t next_room_o
);
    assign bit_o       = nexthop(room_i, target_i);
    assign next_room_o = succ(room_i, bit_o);
endmodule

// File: rtl/rover_route_driver.sv
// Route driver: takes a target room over the cmd handshake and steers the
// rover one hop per clock along a shortest path.
//   clk, reset : clock, asynchronous active-high reset
//   cmd        : target command handshake (slave side)
//   abort      : cancel the active command
//   room_in    : rover registered room
//   travel_out : rover travel bit (Mealy on room_in while driving)
//   busy       : driving a command
//   done       : one-cycle pulse on arrival
//   fault      : one-cycle pulse on abort, divergence or hop-budget overrun
//   hops       : hop count of the current or last command
module rover_route_driver
    import rover_pkg::*;
#(
    parameter int unsigned MAX_HOPS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    rover_route_driver_if.slave  cmd,
    input  logic                 abort,
    input  room_t                room_in,
    output logic                 travel_out,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [3:0]           hops
);
    typedef enum logic {IDLE, DRIVE} state_t;

    state_t     state_q;
    room_t      target_q;
    room_t      expected_q;
    logic       exp_valid_q;
    logic [3:0] hops_q;
    logic [3:0] hops_d;
    logic       busy_q;
    logic       done_q;
    logic       fault_q;

    logic       nh_bit;
    room_t      nh_room;
    logic       arrived;
    logic       diverged;
    logic       timed_out;

    rover_nexthop u_nexthop (
        .room_i      (room_in),
        .target_i    (target_q),
        .bit_o       (nh_bit),
        .next_room_o (nh_room)
    );

    assign arrived   = (room_in == target_q);
    // expected_q holds the room the rover should have reached after the last hop
    assign diverged  = exp_valid_q && (room_in != expected_q);
    assign timed_out = (hops_q == 4'(MAX_HOPS));
    assign hops_d    = (hops_q == 4'hF) ? hops_q : hops_q + 4'd1;

    assign travel_out    = (state_q == DRIVE) ? nh_bit : 1'b0;
    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = busy_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign hops          = hops_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= R0;
            expected_q  <= R0;
            exp_valid_q <= 1'b0;
            hops_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        target_q    <= cmd.cmd_room;
                        hops_q      <= '0;
                        exp_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (abort || diverged) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end else if (arrived) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (timed_out) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        expected_q  <= nh_room;
                        exp_valid_q <= 1'b1;
                        hops_q      <= hops_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rover_route_driver.md
# rover_route_driver

Command-side companion to the land rover room FSM. It accepts a target room over a valid/ready handshake and reads the rover's current room from its registered room output. Each cycle it drives the rover's single `travel_input` bit along a shortest path until the rover reaches the target. It reports arrival, hop count, divergence faults and hop-budget overruns, and sits between the mission controller and the rover FSM.

## Interface
- `MAX_HOPS`, default 8: hop budget per command; legal range 1–15.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `cmd_valid` input 1: a target command is offered.
- `cmd_room` input 3: target room, 0–7.
- `cmd_ready` output 1: high in IDLE only.
- `abort` input 1: cancels the active command.
- `room_in` input 3: rover current room, i.e. the rover's registered state output.
- `travel_out` output 1: drives the rover `travel_input`.
- `busy` output 1: high in DRIVE.
- `done` output 1: one-cycle pulse on arrival.
- `fault` output 1: one-cycle pulse on divergence, timeout or abort.
- `hops` output 4: hop count of the current or last command.

## Operation
- **Rover map** (successor on travel bit 0 / bit 1):
  - R0 → R0 / R1
  - R1 → R0 / R2
  - R2 → R2 / R3
  - R3 → R2 / R4
  - R4 → R4 / R6
  - R5 → R6 / R7
  - R6 → R5 / R4
  - R7 → R7 / R0
- **Room classes:**
  - Park rooms (with a bit-0 self-loop): 0, 2, 4, 7.
  - Transient rooms: 1, 3, 5, 6.
- **Next-hop rule:**
  - `dist(a,t)` is the shortest edge count from a to t over the map.
  - `bit = 0` iff `dist(succ0,t) < dist(succ1,t)`; ties give 1.
- **States:** IDLE and DRIVE.
- **In IDLE:**
  - `travel_out = 0`.
  - Accept on `cmd_valid & cmd_ready`: `target <= cmd_room`, `hops <= 0`, `exp_valid <= 0`, go to DRIVE.
- **In DRIVE**, `travel_out` is combinational (Mealy): `nexthop(room_in, target)`, forced to 0 when `room_in == target`.
- **DRIVE edge priority, highest first:**
  1. `abort`: go to IDLE, pulse `fault`.
  2. Divergence, i.e. `exp_valid & room_in != expected`: go to IDLE, pulse `fault`.
  3. Arrival, i.e. `room_in == target`: go to IDLE, pulse `done`; `hops` is held.
  4. Timeout, i.e. `hops == MAX_HOPS`: go to IDLE, pulse `fault`.
  5. Otherwise: `expected <= succ(room_in, travel_out)`, `exp_valid <= 1`, `hops <= hops + 1`.
- Arrival at a transient room is reported, but it is not a hold. Afterwards the rover follows IDLE's bit 0; R5/R6 oscillate. This is accepted.
- `abort` is ignored in IDLE.
- A command whose target equals the current room completes with 0 hops.

## Timing
- **Reset values:** state IDLE, `cmd_ready = 1`, `travel_out = 0`, `busy = 0`, `done = 0`, `fault = 0`, `hops = 0`, `exp_valid = 0`, `target = 0`, `expected = 0`.
- **Reset mid-DRIVE:** return to IDLE immediately; no `done` or `fault` pulse.
- One rover hop per clock; `travel_out` is valid in the same cycle as `room_in`.
- **Command latency:** accept edge, then the first DRIVE cycle, which drives hop 1. For a shortest path of N hops, `done` is high in the cycle after the edge at which `room_in == target` is observed, i.e. N+2 cycles after the accept edge.
- `done` and `fault` are registered, each exactly one cycle, and mutually exclusive.
- `busy` is registered and tracks DRIVE.
- `hops` saturates at 15.
- A new command is accepted the cycle `done` or `fault` is high, since `cmd_ready` is already 1 in that cycle.

## Structure
- **Package `rover_pkg`:**
  - Room constants R0–R7.
  - Function `succ(room, bit)`.
  - Constant 8x8 `dist` table, built by a BFS constant function.
  - Function `nexthop(room, target)`.
  - The rover FSM shares the room constants.
- **Sub-module `rover_nexthop`:** combinational; inputs `room` and `target`, outputs `bit` and `next_room`.
- **Top:**
  - 1-bit state register.
  - Target, expected-room and hop registers.
  - `done`/`fault` pulse flops.

## Test plan
- Rover FSM connected, reset, `cmd_room = 5` from R0 → `travel_out` 1,1,1,1,1,0; rover path 1,2,3,4,6,5; `done` pulse, `hops = 6`, no `fault`.
- Rover at R6, `cmd_room = 7` → bits 0,1; `done` with `hops = 2`. Then `cmd_room = 0` issued in the `done` cycle → accepted; after R7 oscillation rover path 7 → 0, `hops = 1`.
- Rover parked at R2, `cmd_room = 2` → `done` 2 cycles after accept, `hops = 0`, `travel_out` stays 0.
- Rover stubbed, `room_in` forced to 3 when 1 is expected on the second hop → `fault` pulse, IDLE, `hops = 1`, `done` never rises.
- `MAX_HOPS = 3`, `cmd_room = 5` from R0 → `fault` after 3 hops (rover at R3); `abort` in mid-DRIVE → `fault` next cycle.
- `reset` asserted mid-DRIVE → all outputs return to reset values asynchronously, no pulse; the next command executes normally.
